vs4x400_loader: RTL and testbench

VS4X400_LOADER -- requirements
Module: vs4x400_loader

---
 rtl/vs4x400_pkg.sv | 24 ++
 rtl/vs4x400_byte_packer.sv | 52 +++++
 rtl/vs4x400_loader.sv | 145 ++++++++++++++
 tb/tb_vs4x400_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vs4x400_pkg.sv
// Shared widths, limits and the loader FSM encoding for the vs4x400 vector store
// (also used by vs4x400_dual_core).
package vs4x400_pkg;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 32;
    localparam int ELEM_W      = 8;
    localparam int CNT_W       = 10;
    localparam int MAX_VECTORS = 256;
    localparam int WIDX_W      = 7;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PAD,
        COMMIT
    } load_state_t;

    // Number of 32-bit words occupied by a vector of dim int8 elements.
    function automatic logic [WIDX_W-1:0] words_for_dim(input logic [ELEM_W-1:0] dim);
        return WIDX_W'(({1'b0, dim} + 9'd3) >> 2);
    endfunction

endpackage

// File: rtl/vs4x400_byte_packer.sv
// Packs int8 elements low-byte-first into 32-bit words; a word is emitted on the
// 4th byte or on flush, with word_valid high for exactly the following cycle.
module vs4x400_byte_packer
    import vs4x400_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [ELEM_W-1:0] byte_in,
    input  logic              flush,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid
);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] merged;
    logic [1:0]        pos;

    // Bytes above pos are always zero, so a flushed partial word is zero-padded.
    always_comb begin
        merged = acc | ({24'b0, byte_in} << {pos, 3'b000});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            pos        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            acc        <= '0;
            pos        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                if (pos == 2'd3 || flush) begin
                    word_out   <= merged;
                    word_valid <= 1'b1;
                    acc        <= '0;
                    pos        <= '0;
                end else begin
                    acc <= merged;
                    pos <= pos + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vs4x400_loader.sv
// Streams one int8 vector at a time into word memory at an accumulated base
// address, zero-padding short vectors, and counts committed vectors.
module vs4x400_loader
    import vs4x400_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start_load,
    input  logic [7:0]        dim_size,
    input  logic [7:0]        stride_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  vector_count,
    output logic              busy,
    output logic              err_len,
    output logic              err_overflow
);

    load_state_t       state;
    logic [7:0]        dim_q;
    logic [7:0]        stride_q;
    logic [7:0]        elem_cnt;
    logic [WIDX_W-1:0] word_idx;
    logic [WIDX_W-1:0] n_words;
    logic [ADDR_W-1:0] base;
    logic              pad_we;
    logic              pk_valid;
    logic [DATA_W-1:0] pk_word;
    logic              accept;
    logic              count_hit;
    logic              last_elem;
    logic              word_done;
    logic              start_ovf;
    logic [ADDR_W:0]   start_end;

    assign accept    = in_valid && in_ready;
    assign count_hit = (elem_cnt + 8'd1) == dim_q;
    assign last_elem = count_hit || in_last;
    assign word_done = accept && (elem_cnt[1:0] == 2'd3 || last_elem);
    assign n_words   = words_for_dim(dim_q);
    assign start_end = {1'b0, base} + {6'b0, words_for_dim(dim_size)};
    assign start_ovf = (vector_count == 10'(MAX_VECTORS)) || (start_end > 13'd4096);

    vs4x400_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .byte_valid (accept),
        .byte_in    (in_data),
        .flush      (last_elem),
        .word_out   (pk_word),
        .word_valid (pk_valid)
    );

    // Packer and pad writes never overlap: PAD starts its first write one cycle
    // after the last packed word is issued.
    assign mem_we    = pk_valid || pad_we;
    assign mem_wdata = pk_valid ? pk_word : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dim_q        <= '0;
            stride_q     <= '0;
            elem_cnt     <= '0;
            word_idx     <= '0;
            base         <= '0;
            pad_we       <= 1'b0;
            mem_addr     <= '0;
            vector_count <= '0;
            busy         <= 1'b0;
            in_ready     <= 1'b0;
            err_len      <= 1'b0;
            err_overflow <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            elem_cnt     <= '0;
            word_idx     <= '0;
            base         <= '0;
            pad_we       <= 1'b0;
            vector_count <= '0;
            busy         <= 1'b0;
            in_ready     <= 1'b0;
            err_len      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            pad_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_load) begin
                        if (dim_size == 8'd0) begin
                            err_len <= 1'b1;
                        end else if (start_ovf) begin
                            err_overflow <= 1'b1;
                        end else begin
                            dim_q    <= dim_size;
                            stride_q <= stride_words;
                            elem_cnt <= '0;
                            word_idx <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            state    <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + 8'd1;
                        if (word_done) begin
                            mem_addr <= base + {5'b0, word_idx};
                            word_idx <= word_idx + 7'd1;
                        end
                        if (last_elem) begin
                            in_ready <= 1'b0;
                            if (count_hit != in_last)
                                err_len <= 1'b1;
                            state <= (word_idx + 7'd1 < n_words) ? PAD : COMMIT;
                        end
                    end
                end
                PAD: begin
                    mem_addr <= base + {5'b0, word_idx};
                    pad_we   <= 1'b1;
                    word_idx <= word_idx + 7'd1;
                    if (word_idx + 7'd1 == n_words)
                        state <= COMMIT;
                end
                COMMIT: begin
                    vector_count <= vector_count + 10'd1;
                    base         <= base + {4'b0, stride_q};
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vs4x400_loader.sv
// Directed self-checking bench for vs4x400_loader with a word-memory model.
module tb_vs4x400_loader;
    import vs4x400_pkg::*;

    logic              clk;
    logic              reset;
    logic              clear;
    logic              start_load;
    logic [7:0]        dim_size;
    logic [7:0]        stride_words;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [CNT_W-1:0]  vector_count;
    logic              busy;
    logic              err_len;
    logic              err_overflow;

    int total = 0;
    int bad   = 0;
    int wr_count;
    int stall_drops;
    logic [31:0] mem [0:4095];

    vs4x400_loader dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .start_load   (start_load),
        .dim_size     (dim_size),
        .stride_words (stride_words),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .vector_count (vector_count),
        .busy         (busy),
        .err_len      (err_len),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
            wr_count = 0;
        end else if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_count++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_vector(input logic [7:0] dim, input logic [7:0] stride, input int n,
                               input logic [7:0] first, input int inc, input bit gap);
        int budget;
        @(negedge clk);
        start_load = 1'b1; dim_size = dim; stride_words = stride;
        @(negedge clk);
        start_load = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = first + 8'(i * inc);
            in_last = (i == n - 1);
            in_valid = 1'b1;
            budget = 0;
            while (!in_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                $display("[TB] FAIL send_ready got in_ready=%0b want 1 at elem %0d", in_ready, i);
                bad++; total++;
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            if (gap && i != n - 1) begin
                @(negedge clk);
                if (!in_ready) stall_drops++;
            end
        end
        budget = 0;
        while (busy && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (busy) begin
            $display("[TB] FAIL busy_timeout got busy=%0b want 0", busy);
            bad++; total++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        if (mem_we !== 1'b0) begin $display("[TB] FAIL rst_we got %0b want 0", mem_we); bad++; end total++;
        if (mem_addr !== 12'h0) begin $display("[TB] FAIL rst_addr got %h want 0", mem_addr); bad++; end total++;
        if (mem_wdata !== 32'h0) begin $display("[TB] FAIL rst_wdata got %h want 0", mem_wdata); bad++; end total++;
        if (vector_count !== 10'd0) begin $display("[TB] FAIL rst_count got %0d want 0", vector_count); bad++; end total++;
        if (busy !== 1'b0) begin $display("[TB] FAIL rst_busy got %0b want 0", busy); bad++; end total++;
        if (in_ready !== 1'b0) begin $display("[TB] FAIL rst_ready got %0b want 0", in_ready); bad++; end total++;
        if (err_len !== 1'b0 || err_overflow !== 1'b0) begin
            $display("[TB] FAIL rst_err got len=%0b ovf=%0b want 0 0", err_len, err_overflow); bad++;
        end total++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        send_vector(8'd8, 8'd4, 8, 8'h0A, 0, 1'b0);
        if (mem[0] !== 32'h0A0A0A0A) begin $display("[TB] FAIL single_w0 got %h want 0a0a0a0a", mem[0]); bad++; end total++;
        if (mem[1] !== 32'h0A0A0A0A) begin $display("[TB] FAIL single_w1 got %h want 0a0a0a0a", mem[1]); bad++; end total++;
        if (wr_count !== 2) begin $display("[TB] FAIL single_writes got %0d want 2", wr_count); bad++; end total++;
        if (vector_count !== 10'd1) begin $display("[TB] FAIL single_count got %0d want 1", vector_count); bad++; end total++;
        if (err_len !== 1'b0) begin $display("[TB] FAIL single_errlen got %0b want 0", err_len); bad++; end total++;
    endtask

    task automatic test_partial();
        send_vector(8'd6, 8'd4, 6, 8'h01, 1, 1'b0);
        if (mem[0] !== 32'h04030201) begin $display("[TB] FAIL partial_w0 got %h want 04030201", mem[0]); bad++; end total++;
        if (mem[1] !== 32'h00000605) begin $display("[TB] FAIL partial_w1 got %h want 00000605", mem[1]); bad++; end total++;
        if (wr_count !== 2) begin $display("[TB] FAIL partial_writes got %0d want 2", wr_count); bad++; end total++;
        if (err_len !== 1'b0) begin $display("[TB] FAIL partial_errlen got %0b want 0", err_len); bad++; end total++;
    endtask

    task automatic test_early_last();
        send_vector(8'd8, 8'd4, 3, 8'h01, 1, 1'b0);
        if (mem[0] !== 32'h00030201) begin $display("[TB] FAIL early_w0 got %h want 00030201", mem[0]); bad++; end total++;
        if (mem[1] !== 32'h0) begin $display("[TB] FAIL early_pad got %h want 0", mem[1]); bad++; end total++;
        if (wr_count !== 2) begin $display("[TB] FAIL early_writes got %0d want 2", wr_count); bad++; end total++;
        if (err_len !== 1'b1) begin $display("[TB] FAIL early_errlen got %0b want 1", err_len); bad++; end total++;
        if (vector_count !== 10'd1) begin $display("[TB] FAIL early_count got %0d want 1", vector_count); bad++; end total++;
    endtask

    task automatic test_stall();
        stall_drops = 0;
        send_vector(8'd8, 8'd4, 8, 8'h01, 1, 1'b1);
        if (mem[0] !== 32'h04030201) begin $display("[TB] FAIL stall_w0 got %h want 04030201", mem[0]); bad++; end total++;
        if (mem[1] !== 32'h08070605) begin $display("[TB] FAIL stall_w1 got %h want 08070605", mem[1]); bad++; end total++;
        if (stall_drops !== 0) begin $display("[TB] FAIL stall_ready got %0d drops want 0", stall_drops); bad++; end total++;
        if (vector_count !== 10'd1) begin $display("[TB] FAIL stall_count got %0d want 1", vector_count); bad++; end total++;
    endtask

    task automatic test_three_loads();
        send_vector(8'd8, 8'd4, 8, 8'h0A, 0, 1'b0);
        send_vector(8'd8, 8'd4, 4, 8'h01, 0, 1'b0);
        send_vector(8'd8, 8'd4, 4, 8'hF6, 0, 1'b0);
        if (mem[1] !== 32'h0A0A0A0A) begin $display("[TB] FAIL three_w1 got %h want 0a0a0a0a", mem[1]); bad++; end total++;
        if (mem[4] !== 32'h01010101) begin $display("[TB] FAIL three_w4 got %h want 01010101", mem[4]); bad++; end total++;
        if (mem[5] !== 32'h0) begin $display("[TB] FAIL three_w5 got %h want 0", mem[5]); bad++; end total++;
        if (mem[8] !== 32'hF6F6F6F6) begin $display("[TB] FAIL three_w8 got %h want f6f6f6f6", mem[8]); bad++; end total++;
        if (wr_count !== 6) begin $display("[TB] FAIL three_writes got %0d want 6", wr_count); bad++; end total++;
        if (vector_count !== 10'd3) begin $display("[TB] FAIL three_count got %0d want 3", vector_count); bad++; end total++;
    endtask

    task automatic test_overflow_clear();
        int wc;
        for (int v = 0; v < 16; v++) send_vector(8'd68, 8'd255, 68, 8'h11, 0, 1'b0);
        if (vector_count !== 10'd16) begin $display("[TB] FAIL ovf_count16 got %0d want 16", vector_count); bad++; end total++;
        if (mem[3841] !== 32'h11111111) begin $display("[TB] FAIL ovf_lastword got %h want 11111111", mem[3841]); bad++; end total++;
        if (err_overflow !== 1'b0) begin $display("[TB] FAIL ovf_early got %0b want 0", err_overflow); bad++; end total++;
        wc = wr_count;
        @(negedge clk);
        start_load = 1'b1; dim_size = 8'd68; stride_words = 8'd255;
        @(negedge clk);
        start_load = 1'b0;
        repeat (3) @(negedge clk);
        if (err_overflow !== 1'b1) begin $display("[TB] FAIL ovf_flag got %0b want 1", err_overflow); bad++; end total++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("[TB] FAIL ovf_idle got busy=%0b ready=%0b want 0 0", busy, in_ready); bad++;
        end total++;
        if (wr_count !== wc) begin $display("[TB] FAIL ovf_nowrite got %0d want %0d", wr_count, wc); bad++; end total++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        if (vector_count !== 10'd0 || err_overflow !== 1'b0) begin
            $display("[TB] FAIL clr_state got count=%0d ovf=%0b want 0 0", vector_count, err_overflow); bad++;
        end total++;
        start_load = 1'b1; dim_size = 8'd8; stride_words = 8'd4;
        @(negedge clk);
        start_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h21 + 8'(i);
            @(negedge clk);
        end
        wc = wr_count;
        in_data = 8'h24; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        repeat (5) @(negedge clk);
        if (wr_count !== wc) begin $display("[TB] FAIL clr_nowrite got %0d want %0d", wr_count, wc); bad++; end total++;
        if (vector_count !== 10'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("[TB] FAIL clr_idle got count=%0d busy=%0b ready=%0b want 0 0 0", vector_count, busy, in_ready); bad++;
        end total++;
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        start_load = 1'b1; dim_size = 8'd0; stride_words = 8'd4;
        @(negedge clk);
        start_load = 1'b0;
        @(negedge clk);
        if (err_len !== 1'b1 || busy !== 1'b0) begin
            $display("[TB] FAIL zero_dim got errlen=%0b busy=%0b want 1 0", err_len, busy); bad++;
        end total++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        if (err_len !== 1'b0) begin $display("[TB] FAIL zero_clr got %0b want 0", err_len); bad++; end total++;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; start_load = 1'b0;
        dim_size = 8'd0; stride_words = 8'd0;
        in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0;
        test_reset();
        test_single();
        do_reset();
        test_partial();
        do_reset();
        test_early_last();
        do_reset();
        test_stall();
        do_reset();
        test_three_loads();
        do_reset();
        test_overflow_clear();
        test_len_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
